// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_transmitter
//  Description : UART-style asynchronous serial transmitter. Takes an N-bit
//                word over the dav_/rfd handshake and sends it on txd as one
//                start bit (0), N data bits LSB first, then the stop bit(s)
//                (1). Every bit is held for exactly K clock periods.
//                Optional macro TX_TWO_STOP_EN: send two stop bits instead
//                of one, giving (N + 3) * K clocks per frame.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_transmitter #(
    parameter int N = 8,
    parameter int K = 16
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] data,
    input  logic         dav_,
    output logic         rfd,
    output logic         txd
);

    // Bit timer counts K down to 1; bit counter must hold N as well as the
    // stop-bit count, so it is never narrower than 2 bits.
    localparam int WW = $clog2(K + 1);
    localparam int CW = (N < 2) ? 2 : $clog2(N + 1);

`ifdef TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    localparam logic [WW-1:0] C_WAIT_LOAD = WW'(K);
    localparam logic [WW-1:0] C_WAIT_ONE  = WW'(1);
    localparam logic [CW-1:0] C_COUNT_LOAD = CW'(N);
    localparam logic [CW-1:0] C_STOP_LOAD  = CW'(STOP_BITS);
    localparam logic [CW-1:0] C_COUNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [N-1:0]    r_buffer, w_buffer;
    logic [WW-1:0]   r_wait, w_wait;
    logic [CW-1:0]   r_count, w_count;
    logic            r_txd, w_txd;
    logic            r_rfd, w_rfd;
    logic            w_wait_done;

    assign w_wait_done = (r_wait == C_WAIT_ONE);

    // Next-state and datapath: each bit period ends on the edge that sees
    // the timer at 1, and that same edge reloads the timer with K.
    always_comb begin
        w_state  = r_state;
        w_buffer = r_buffer;
        w_wait   = r_wait;
        w_count  = r_count;
        w_txd    = r_txd;
        w_rfd    = r_rfd;
        unique case (r_state)
            S_IDLE: begin
                if (!dav_) begin
                    w_buffer = data;
                    w_rfd    = 1'b0;
                    w_state  = S_ACK;
                end
            end
            S_ACK: begin
                if (dav_) begin
                    w_txd   = 1'b0;
                    w_wait  = C_WAIT_LOAD;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_wait_done) begin
                    w_txd    = r_buffer[0];
                    w_buffer = r_buffer >> 1;
                    w_count  = C_COUNT_LOAD;
                    w_wait   = C_WAIT_LOAD;
                    w_state  = S_DATA;
                end else begin
                    w_wait = r_wait - C_WAIT_ONE;
                end
            end
            S_DATA: begin
                if (w_wait_done) begin
                    w_wait = C_WAIT_LOAD;
                    if (r_count == C_COUNT_ONE) begin
                        w_txd   = 1'b1;
                        w_count = C_STOP_LOAD;
                        w_state = S_STOP;
                    end else begin
                        w_txd    = r_buffer[0];
                        w_buffer = r_buffer >> 1;
                        w_count  = r_count - C_COUNT_ONE;
                    end
                end else begin
                    w_wait = r_wait - C_WAIT_ONE;
                end
            end
            S_STOP: begin
                // The bit counter is reused to count stop bits.
                if (w_wait_done) begin
                    if (r_count == C_COUNT_ONE) begin
                        w_rfd   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_count = r_count - C_COUNT_ONE;
                        w_wait  = C_WAIT_LOAD;
                    end
                end else begin
                    w_wait = r_wait - C_WAIT_ONE;
                end
            end
            default: begin
                w_txd   = 1'b1;
                w_rfd   = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    // State register; reset forces the line idle immediately, mid-frame too.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state  <= S_IDLE;
            r_buffer <= '0;
            r_wait   <= '0;
            r_count  <= '0;
            r_txd    <= 1'b1;
            r_rfd    <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_buffer <= w_buffer;
            r_wait   <= w_wait;
            r_count  <= w_count;
            r_txd    <= w_txd;
            r_rfd    <= w_rfd;
        end
    end

    assign txd = r_txd;
    assign rfd = r_rfd;

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_transmitter
//  Description : Self-checking bench for serial_transmitter. A reference
//                model builds each expected frame as a list of line levels
//                (start, data LSB first, stop bits) and every bit is checked
//                for exactly K clocks of the expected level.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_transmitter;

    localparam int N = 8;
    localparam int K = 16;
`ifdef TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif
    localparam int NBITS = 1 + N + STOPS;
    localparam int FRAME = NBITS * K;

    logic         clock;
    logic         reset_;
    logic [N-1:0] data;
    logic         dav_;
    logic         rfd;
    logic         txd;

    int n_tests = 0;
    int n_fail  = 0;

    serial_transmitter #(.N(N), .K(K)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .data   (data),
        .dav_   (dav_),
        .rfd    (rfd),
        .txd    (txd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // Sends one word and checks the whole frame. All driving happens 1 time
    // unit after a rising edge. abort_at >= 0 asserts reset_ inside the frame
    // at that clock index and returns with reset still asserted.
    task automatic send_frame(input logic [N-1:0] word, input bit scramble,
                              input bit glitch, input int abort_at);
        logic       samples [0:FRAME-1];
        logic [N+STOPS:0] levels;
        logic [63:0] obs, want;
        int wait_cnt;
        int rfd_high;

        wait_cnt = 0;
        while (rfd !== 1'b1 && wait_cnt < 200) begin
            @(posedge clock); #1;
            wait_cnt++;
        end
        check("rfd_ready", {63'd0, rfd}, 64'd1);

        // Reference frame: start 0, data LSB first, then stop bit(s).
        levels = '1;
        levels[0] = 1'b0;
        for (int i = 0; i < N; i++) levels[i+1] = word[i];

        data = word;
        dav_ = 1'b0;
        @(posedge clock); #1;
        check("rfd_capture", {63'd0, rfd}, 64'd0);
        check("txd_ack", {63'd0, txd}, 64'd1);
        data = scramble ? N'($urandom) : word;
        dav_ = 1'b1;

        rfd_high = 0;
        for (int j = 0; j <= FRAME; j++) begin
            @(posedge clock); #1;
            if (j == FRAME) begin
                check("rfd_rise", {63'd0, rfd}, 64'd1);
                check("txd_end", {63'd0, txd}, 64'd1);
            end else begin
                samples[j] = txd;
                if (rfd !== 1'b0) rfd_high++;
                if (scramble) data = N'($urandom);
                if (glitch && j == 2*K) dav_ = 1'b0;
                if (glitch && j == 3*K) dav_ = 1'b1;
                if (j == abort_at) begin
                    #2 reset_ = 1'b0;
                    #1;
                    check("abort_txd", {63'd0, txd}, 64'd1);
                    check("abort_rfd", {63'd0, rfd}, 64'd1);
                    dav_ = 1'b1;
                    return;
                end
            end
        end

        check("rfd_busy", 64'(rfd_high), 64'd0);
        for (int b = 0; b < NBITS; b++) begin
            obs  = '0;
            want = '0;
            for (int i = 0; i < K; i++) begin
                obs[i]  = samples[b*K + i];
                want[i] = levels[b];
            end
            check($sformatf("bit%0d_w%02h", b, word), obs, want);
        end
    endtask

    initial begin
        int txd_bad;
        int rfd_bad;
        int gap;

        reset_ = 1'b1;
        dav_   = 1'b1;
        data   = '0;
        #2 reset_ = 1'b0;
        #1;
        check("reset_txd", {63'd0, txd}, 64'd1);
        check("reset_rfd", {63'd0, rfd}, 64'd1);
        repeat (3) @(posedge clock);
        #1 reset_ = 1'b1;

        // Idle line: no activity for 100 clocks with dav_ high.
        txd_bad = 0;
        rfd_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (txd !== 1'b1) txd_bad++;
            if (rfd !== 1'b1) rfd_bad++;
        end
        check("idle_txd", 64'(txd_bad), 64'd0);
        check("idle_rfd", 64'(rfd_bad), 64'd0);

        // Single frame, then data changing during transmission.
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);

        // Reset in the middle of the 4th data bit.
        send_frame(8'hC7, 1'b0, 1'b0, 4*K + K/2);
        repeat (2) @(posedge clock);
        #1;
        check("held_txd", {63'd0, txd}, 64'd1);
        check("held_rfd", {63'd0, rfd}, 64'd1);
        reset_ = 1'b1;
        send_frame(8'h01, 1'b0, 1'b0, -1);

        // Back-to-back frames, each request issued as soon as rfd is seen.
        send_frame(8'h00, 1'b0, 1'b0, -1);
        send_frame(8'hFF, 1'b0, 1'b0, -1);
        send_frame(8'h55, 1'b0, 1'b0, -1);
        send_frame(8'h81, 1'b0, 1'b0, -1);
        send_frame(8'h7E, 1'b0, 1'b0, -1);

        // Randomized words, gaps, data scrambling and stray dav_ pulses.
        for (int t = 0; t < 20; t++) begin
            gap = $urandom_range(0, 5);
            if (gap > 0) begin
                repeat (gap) @(posedge clock);
                #1;
            end
            send_frame(N'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
